lcd_cmd_issuer: RTL and testbench

LCD_CMD_ISSUER -- requirements
Module: lcd_cmd_issuer

---
 rtl/lcd_cmd_issuer.sv | 153 +++++++++++++++
 tb/tb_lcd_cmd_issuer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_issuer.sv
// Command issuer: 8-deep opcode FIFO feeding an LCD controller with paced strobes.
// Optional build macro CMD_FILTER_EN rejects opcodes above 11 and pulses push_err.
module lcd_cmd_issuer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] push_cmd,
  input  logic       push_valid,
  output logic       push_ready,
  input  logic       busy,
  input  logic       done,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic [3:0] fifo_level,
  output logic       push_err,
  output logic       seq_done
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StTerm,
    StFin
  } state_e;

  state_e     r_state;
  state_e     w_state_next;

  logic [3:0] r_mem [8];
  logic [2:0] r_wr_ptr;
  logic [2:0] r_rd_ptr;
  logic [3:0] r_level;
  logic [3:0] r_cmd;

  logic       w_cmd_ok;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_head;
  logic       w_load_cmd;

  assign w_head = r_mem[r_rd_ptr];

`ifdef CMD_FILTER_EN
  logic r_push_err;

  assign w_cmd_ok = (push_cmd <= 4'd11);

  // Filtered pushes still see push_ready=1; the error is reported one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_push_err <= 1'b0;
    end else begin
      r_push_err <= push_valid && push_ready && !w_cmd_ok;
    end
  end

  assign push_err = r_push_err;
`else
  assign w_cmd_ok = 1'b1;
  assign push_err = 1'b0;
`endif

  assign w_push     = push_valid && push_ready && w_cmd_ok;
  assign w_pop      = (r_state == StIssue);
  assign w_load_cmd = (r_state == StIdle) && (w_state_next == StIssue);

  // Storage is not reset: pointers and level alone define the valid contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_cmd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_level  <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 3'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 3'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // The head is captured on entry to ISSUE so cmd is registered and then holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd <= 4'd0;
    end else if (w_load_cmd) begin
      r_cmd <= w_head;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if ((r_level != 4'd0) && !busy) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_state_next = (r_cmd == 4'd0) ? StTerm : StGuard;
      end
      StGuard: begin
        w_state_next = StWait;
      end
      StWait: begin
        if (!busy) begin
          w_state_next = StIdle;
        end
      end
      StTerm: begin
        if (done) begin
          w_state_next = StFin;
        end
      end
      StFin: begin
        w_state_next = StFin;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    cmd        = r_cmd;
    fifo_level = r_level;
    cmd_valid  = (r_state == StIssue);
    seq_done   = (r_state == StFin);
    push_ready = (r_level < 4'd8) && (r_state != StTerm) && (r_state != StFin);
  end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Self-checking bench for lcd_cmd_issuer: timestamp-based reference model plus directed scenarios.
// Build with +define+CMD_FILTER_EN to check the opcode-filter variant.
module tb_lcd_cmd_issuer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] push_cmd = 4'd0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [3:0] fifo_level;
  logic       push_err;
  logic       seq_done;

  lcd_cmd_issuer dut (
    .clk       (clk),
    .reset     (reset),
    .push_cmd  (push_cmd),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .busy      (busy),
    .done      (done),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .fifo_level(fifo_level),
    .push_err  (push_err),
    .seq_done  (seq_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of opcodes plus cycle timestamps of the issue rhythm.
  int q[$];
  int cyc = 0;
  int m_issue_at = -1;
  int m_last_issue = -1;
  int m_clear_at = -1;
  int m_last_cmd = 0;
  bit m_term = 0;
  bit m_fin = 0;
  bit m_err = 0;
  int s_cmd[$];
  int s_cyc[$];

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_issue_at = -1;
      m_last_issue = -1;
      m_clear_at = -1;
      m_last_cmd = 0;
      m_term = 0;
      m_fin = 0;
      m_err = 0;
    end else begin
      int  lvl0;
      bit  acc;
      bit  filt;
      bit  idle;
      lvl0 = q.size();
      acc  = push_valid && (lvl0 < 8) && !m_term;
`ifdef CMD_FILTER_EN
      filt = (push_cmd > 4'd11);
`else
      filt = 1'b0;
`endif
      idle = !m_term && (m_issue_at != cyc) &&
             (m_last_issue < 0 || (m_clear_at >= 0 && cyc > m_clear_at));
      if (m_issue_at == cyc) begin
        m_last_cmd   = q.pop_front();
        m_last_issue = cyc;
        m_clear_at   = -1;
        if (m_last_cmd == 0) m_term = 1;
      end else if (!m_term && m_last_issue >= 0 && m_clear_at < 0 &&
                   cyc >= m_last_issue + 2 && !busy) begin
        m_clear_at = cyc;
      end
      if (idle && lvl0 > 0 && !busy) m_issue_at = cyc + 1;
      if (m_term && m_last_issue < cyc && done) m_fin = 1;
      m_err = acc && filt;
      if (acc && !filt) q.push_back(int'(push_cmd));
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (reset) begin
      bit e_valid;
      int e_cmd;
      e_valid = (m_issue_at == cyc);
      e_cmd   = (e_valid && q.size() > 0) ? q[0] : m_last_cmd;
      chk("cmd_valid", int'(cmd_valid), int'(e_valid));
      chk("cmd", int'(cmd), e_cmd);
      chk("fifo_level", int'(fifo_level), q.size());
      chk("push_ready", int'(push_ready), int'(q.size() < 8 && !m_term));
      chk("seq_done", int'(seq_done), int'(m_fin));
      chk("push_err", int'(push_err), int'(m_err));
      if (cmd_valid) begin
        s_cmd.push_back(int'(cmd));
        s_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    push_valid = 1'b1;
    push_cmd   = v[3:0];
    tick();
    push_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    push_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int n0;
    int f;
    bit seen;

    // Reset values while reset is held low
    tick();
    tick();
    @(negedge clk);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_seq_done", int'(seq_done), 0);
    chk("rst_push_err", int'(push_err), 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(push_ready), 1);
    tick();

    // 3, 5, 0: paced strobes, stop in TERM, then done -> sticky seq_done
    push(3);
    push(5);
    push(0);
    repeat (20) tick();
    chk("s1_strobe_count", s_cmd.size(), 3);
    if (s_cmd.size() == 3) begin
      chk("s1_cmd0", s_cmd[0], 3);
      chk("s1_cmd1", s_cmd[1], 5);
      chk("s1_cmd2", s_cmd[2], 0);
      chk("s1_gap01", s_cyc[1] - s_cyc[0], 4);
      chk("s1_gap12", s_cyc[2] - s_cyc[1], 4);
    end
    @(negedge clk);
    chk("s1_level_empty", int'(fifo_level), 0);
    chk("s1_ready_term", int'(push_ready), 0);
    tick();
    push(4);
    @(negedge clk);
    chk("s1_push_in_term", int'(fifo_level), 0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    @(negedge clk);
    chk("s1_seq_done", int'(seq_done), 1);
    repeat (3) tick();
    chk("s1_seq_done_sticky", int'(seq_done), 1);

    // Fill to 8 while busy blocks issue; 9th push ignored
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 8; i++) push(1);
    @(negedge clk);
    chk("s2_level_full", int'(fifo_level), 8);
    chk("s2_ready_full", int'(push_ready), 0);
    tick();
    push(1);
    @(negedge clk);
    chk("s2_level_after_9th", int'(fifo_level), 8);
    tick();
    busy = 1'b0;
    repeat (40) tick();
    chk("s2_drained", int'(fifo_level), 0);

    // busy held 10 cycles after GUARD delays the next strobe
    do_reset();
    push(2);
    push(7);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (cmd_valid) seen = 1'b1;
      else tick();
    end
    chk("s3_first_strobe", int'(seen), 1);
    tick();
    busy = 1'b1;
    n0 = s_cmd.size();
    repeat (10) tick();
    busy = 1'b0;
    f = cyc;
    chk("s3_no_strobe_busy", s_cmd.size(), n0);
    repeat (6) tick();
    chk("s3_strobe_after", s_cmd.size(), n0 + 1);
    if (s_cmd.size() == n0 + 1) begin
      chk("s3_strobe_cycle", s_cyc[n0] - f, 2);
      chk("s3_strobe_cmd", s_cmd[n0], 7);
    end

    // Reset while in WAIT with three entries pending
    do_reset();
    push(1);
    push(2);
    busy = 1'b1;
    push(3);
    push(4);
    tick();
    @(negedge clk);
    chk("s4_level_wait", int'(fifo_level), 3);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("s4_rst_level", int'(fifo_level), 0);
    chk("s4_rst_valid", int'(cmd_valid), 0);
    chk("s4_rst_cmd", int'(cmd), 0);
    tick();
    reset = 1'b1;
    busy  = 1'b0;
    n0 = s_cmd.size();
    repeat (10) tick();
    chk("s4_no_strobe", s_cmd.size(), n0);
    push(6);
    repeat (4) tick();
    chk("s4_new_strobe", s_cmd.size(), n0 + 1);
    if (s_cmd.size() == n0 + 1) chk("s4_new_cmd", s_cmd[n0], 6);

    // Opcode 13: filtered or forwarded depending on the build
    do_reset();
    n0 = s_cmd.size();
    push(13);
`ifdef CMD_FILTER_EN
    @(negedge clk);
    chk("s5_err_pulse", int'(push_err), 1);
    chk("s5_level", int'(fifo_level), 0);
    tick();
    chk("s5_err_clear", int'(push_err), 0);
    repeat (4) tick();
    chk("s5_no_strobe", s_cmd.size(), n0);
`else
    repeat (4) tick();
    chk("s5_strobe", s_cmd.size(), n0 + 1);
    if (s_cmd.size() == n0 + 1) chk("s5_cmd13", s_cmd[n0], 13);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
